// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-requester SRAM-like bus arbiter with in-order response routing
// Data side has fixed priority; a grant stays locked until its address handshake completes.

module sram_bus_arbiter_owner_q #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     push_owner,
    input  logic                     pop,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [DEPTH-1:0] r_owner;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_owner[r_wr_ptr] <= push_owner;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_owner[r_rd_ptr];
    assign count = r_count;
endmodule

module sram_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_head;
    logic [CW-1:0] w_count;

    assign w_full = (w_count == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In IDLE a grant that misses mem_addr_ok is pinned until memory accepts it.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (!w_full) begin
                        if (data_req) begin
                            w_grant_d = 1'b1;
                            if (!mem_addr_ok) w_next_state = LOCK_D;
                        end else if (inst_req) begin
                            w_grant_i = 1'b1;
                            if (!mem_addr_ok) w_next_state = LOCK_I;
                        end
                    end
                end
                LOCK_I: begin
                    w_grant_i = 1'b1;
                    if (mem_addr_ok) w_next_state = IDLE;
                end
                LOCK_D: begin
                    w_grant_d = 1'b1;
                    if (mem_addr_ok) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (w_grant_d) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (w_grant_i) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    assign mem_req      = w_grant_i | w_grant_d;
    assign inst_addr_ok = w_grant_i & mem_addr_ok;
    assign data_addr_ok = w_grant_d & mem_addr_ok;

    assign w_push = mem_req & mem_addr_ok;
    assign w_pop  = !reset & mem_data_ok & (w_count != '0);

    sram_bus_arbiter_owner_q #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_q (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_owner (w_grant_d),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count)
    );

    assign inst_data_ok = w_pop & !w_head;
    assign data_data_ok = w_pop & w_head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clr();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        clr();
        reset = 1;
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1; mem_data_ok = 1;
        cyc(); cyc(); #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
            errors++; $display("FAIL reset_handshakes got %b want 0000",
                               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        cyc(); clr(); reset = 0;
        cyc(); #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_mem_req got %b want 0", mem_req); end
    endtask

    task automatic test_single_inst();
        cyc(); inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1; #1;
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110 || mem_addr !== 32'h1c000000) begin
            errors++; $display("FAIL t1_grant req/iok/dok=%b addr=%h want 110 1c000000",
                               {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        end
        cyc(); clr(); #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL t1_release req=%b addr=%h want 0 0", mem_req, mem_addr);
        end
        cyc(); mem_data_ok = 1; mem_rdata = 32'h02800c0c; #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h02800c0c) begin
            errors++; $display("FAIL t1_resp iok/dok=%b rdata=%h want 10 02800c0c",
                               {inst_data_ok, data_data_ok}, inst_rdata);
        end
        cyc(); clr();
    endtask

    task automatic test_priority();
        cyc();
        inst_req = 1; inst_addr = 32'h1c000040;
        data_req = 1; data_addr = 32'h1c008000; data_wr = 1; data_wdata = 32'hdeadbeef; data_wstrb = 4'h3;
        mem_addr_ok = 1; #1;
        checks++;
        if (mem_addr !== 32'h1c008000 || {data_addr_ok, inst_addr_ok} !== 2'b10 ||
            mem_wr !== 1'b1 || mem_wdata !== 32'hdeadbeef || mem_wstrb !== 4'h3) begin
            errors++; $display("FAIL t2_data_first addr=%h dok/iok=%b wr=%b wdata=%h strb=%h",
                               mem_addr, {data_addr_ok, inst_addr_ok}, mem_wr, mem_wdata, mem_wstrb);
        end
        cyc(); data_req = 0; data_wr = 0; #1;
        checks++;
        if (mem_addr !== 32'h1c000040 || {data_addr_ok, inst_addr_ok} !== 2'b01) begin
            errors++; $display("FAIL t2_inst_second addr=%h dok/iok=%b want 1c000040 01",
                               mem_addr, {data_addr_ok, inst_addr_ok});
        end
        cyc(); clr(); mem_data_ok = 1; mem_rdata = 32'h11111111; #1;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'h11111111) begin
            errors++; $display("FAIL t2_resp0 dok/iok=%b rdata=%h want 10 11111111",
                               {data_data_ok, inst_data_ok}, data_rdata);
        end
        cyc(); mem_rdata = 32'h22222222; #1;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b01 || inst_rdata !== 32'h22222222) begin
            errors++; $display("FAIL t2_resp1 dok/iok=%b rdata=%h want 01 22222222",
                               {data_data_ok, inst_data_ok}, inst_rdata);
        end
        cyc(); clr();
    endtask

    task automatic test_lock();
        cyc(); inst_req = 1; inst_addr = 32'h1c000100; #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1c000100 || inst_addr_ok !== 1'b0) begin
            errors++; $display("FAIL t3_c0 req=%b addr=%h iok=%b", mem_req, mem_addr, inst_addr_ok);
        end
        for (int c = 1; c < 3; c++) begin
            cyc(); data_req = 1; data_addr = 32'h1c008100; #1;
            checks++;
            if (mem_addr !== 32'h1c000100 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin
                errors++; $display("FAIL t3_hold%0d addr=%h iok/dok=%b want 1c000100 00",
                                   c, mem_addr, {inst_addr_ok, data_addr_ok});
            end
        end
        cyc(); mem_addr_ok = 1; #1;
        checks++;
        if (mem_addr !== 32'h1c000100 || {inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL t3_accept addr=%h iok/dok=%b want 1c000100 10",
                               mem_addr, {inst_addr_ok, data_addr_ok});
        end
        cyc(); inst_req = 0; #1;
        checks++;
        if (mem_addr !== 32'h1c008100 || {inst_addr_ok, data_addr_ok} !== 2'b01) begin
            errors++; $display("FAIL t3_data_next addr=%h iok/dok=%b want 1c008100 01",
                               mem_addr, {inst_addr_ok, data_addr_ok});
        end
        cyc(); clr(); mem_data_ok = 1; #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL t3_resp0 iok/dok=%b want 10", {inst_data_ok, data_data_ok});
        end
        cyc(); #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL t3_resp1 iok/dok=%b want 01", {inst_data_ok, data_data_ok});
        end
        cyc(); clr();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            cyc(); data_req = 1; data_addr = 32'h1c008200 + 32'(4 * k); mem_addr_ok = 1; #1;
            checks++;
            if (data_addr_ok !== 1'b1) begin
                errors++; $display("FAIL t4_fill%0d data_addr_ok got %b want 1", k, data_addr_ok);
            end
        end
        cyc(); #1;
        checks++;
        if ({mem_req, data_addr_ok} !== 2'b00) begin
            errors++; $display("FAIL t4_full req/dok=%b want 00", {mem_req, data_addr_ok});
        end
        cyc(); mem_data_ok = 1; #1;
        checks++;
        if ({mem_req, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL t4_pop_at_full req/ddok=%b want 01", {mem_req, data_data_ok});
        end
        cyc(); mem_data_ok = 0; #1;
        checks++;
        if ({mem_req, data_addr_ok} !== 2'b11) begin
            errors++; $display("FAIL t4_reopen req/dok=%b want 11", {mem_req, data_addr_ok});
        end
        cyc(); data_req = 0; mem_data_ok = 1; #1;
        checks++;
        if (data_data_ok !== 1'b1) begin
            errors++; $display("FAIL t4_to3 data_data_ok got %b want 1", data_data_ok);
        end
        cyc(); data_req = 1; mem_data_ok = 1; #1;
        checks++;
        if ({data_addr_ok, data_data_ok} !== 2'b11) begin
            errors++; $display("FAIL t4_pushpop addr_ok/data_ok=%b want 11", {data_addr_ok, data_data_ok});
        end
        cyc(); mem_data_ok = 0; #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++; $display("FAIL t4_last_slot data_addr_ok got %b want 1", data_addr_ok);
        end
        cyc(); #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL t4_full_again mem_req got %b want 0", mem_req);
        end
        data_req = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(); mem_data_ok = 1; #1;
            checks++;
            if (data_data_ok !== (k < 4)) begin
                errors++; $display("FAIL t4_drain%0d data_data_ok got %b want %b", k, data_data_ok, k < 4);
            end
        end
        cyc(); clr();
    endtask

    task automatic test_order_wrap();
        logic seq [12] = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0};
        int issued = 0;
        int answered = 0;
        int cycles = 0;
        logic exp_d;
        while (answered < 12 && cycles < 400) begin
            cyc(); clr();
            cycles++;
            if (issued < 12 && (issued - answered) < 4) begin
                if (seq[issued]) begin data_req = 1; data_addr = 32'h1c008000 + 32'(issued); end
                else begin inst_req = 1; inst_addr = 32'h1c000000 + 32'(issued); end
                mem_addr_ok = 1'($urandom_range(0, 1));
            end
            if (issued > answered && $urandom_range(0, 2) == 0) begin
                mem_data_ok = 1;
                mem_rdata = $urandom;
            end
            #1;
            if (mem_addr_ok) begin
                checks++;
                if ({data_addr_ok, inst_addr_ok} !== {seq[issued], !seq[issued]}) begin
                    errors++; $display("FAIL t5_grant%0d dok/iok=%b want %b", issued,
                                       {data_addr_ok, inst_addr_ok}, {seq[issued], !seq[issued]});
                end
                issued++;
            end
            if (mem_data_ok) begin
                exp_d = seq[answered];
                checks++;
                if ({data_data_ok, inst_data_ok} !== {exp_d, !exp_d} ||
                    (exp_d ? data_rdata : inst_rdata) !== mem_rdata) begin
                    errors++; $display("FAIL t5_resp%0d dok/iok=%b want %b", answered,
                                       {data_data_ok, inst_data_ok}, {exp_d, !exp_d});
                end
                answered++;
            end
        end
        checks++;
        if (answered != 12) begin
            errors++; $display("FAIL t5_timeout answered %0d want 12", answered);
        end
        cyc(); clr();
    endtask

    task automatic test_reset_mid_op();
        for (int k = 0; k < 2; k++) begin
            cyc(); inst_req = 1; inst_addr = 32'h1c000300 + 32'(4 * k); mem_addr_ok = 1;
        end
        cyc(); clr(); reset = 1; #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL t6_in_reset mem_req got %b want 0", mem_req); end
        cyc(); reset = 0; mem_data_ok = 1; mem_rdata = 32'h33333333; #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL t6_stray iok/dok=%b want 00", {inst_data_ok, data_data_ok});
        end
        for (int k = 0; k < 4; k++) begin
            cyc(); clr(); data_req = 1; mem_addr_ok = 1; #1;
            checks++;
            if (data_addr_ok !== 1'b1) begin
                errors++; $display("FAIL t6_refill%0d data_addr_ok got %b want 1", k, data_addr_ok);
            end
        end
        cyc(); #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL t6_full mem_req got %b want 0", mem_req); end
        cyc(); clr(); reset = 1;
        cyc(); reset = 0;
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_priority();
        test_lock();
        test_full();
        test_order_wrap();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
